// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, parity modes, oversampling rate
// and the divider calculation used by the oversample tick generator.
package uart_pkg;

  localparam int OS_RATE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int calc_os_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * OS_RATE);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: one-cycle pulse every OS_DIV clocks.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rstn,
  output logic os_tick
);

  localparam int OS_DIV = calc_os_div(CLK_FREQ, BAUD_RATE);
  localparam int CW     = (OS_DIV < 2) ? 1 : $clog2(OS_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(OS_DIV - 1);

  // A divider below 2 cannot produce a distinct tick pulse.
  if (OS_DIV < 2) begin : g_os_div_check
    $error("uart_os_tick: OS_DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next-state for the divider: wrap at OS_DIV-1 and flag the wrap.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Divider counter and registered tick output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign os_tick = tick_q;

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver with 2-of-3 majority sampling, start-bit
// glitch rejection, optional parity check and a valid/ready holding register.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun
);

  localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  localparam logic [3:0] CNT_S7  = 4'd7;
  localparam logic [3:0] CNT_S8  = 4'd8;
  localparam logic [3:0] CNT_S9  = 4'd9;
  localparam logic [3:0] CNT_END = 4'd15;

  logic                  os_tick_s;
  logic [1:0]            sync_q;
  logic                  rxd_s;
  logic                  maj_s;
  logic                  par_exp_s;
  logic [DATA_WIDTH:0]   shift_ins_s;

  rx_state_e             state_q, state_d;
  logic [3:0]            os_cnt_q, os_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  overrun_q, overrun_d;

  uart_os_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_os_tick (
    .clk     (clk),
    .rstn    (rstn),
    .os_tick (os_tick_s)
  );

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxd_s = sync_q[1];

  // Samples at os_cnt 7 and 8 are stored; the third is the live line at 9.
  assign maj_s = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

  // Expected parity bit: XOR of the data for even, its inverse for odd.
  assign par_exp_s = (PAR_MODE == ODD) ? ~(^shift_q) : (^shift_q);

  // New bit enters at the MSB so the word ends up LSB-first aligned.
  assign shift_ins_s = {maj_s, shift_q};

  // Receiver FSM, sampler, shifter and holding-register next-state logic.
  always_comb begin
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    rx_data_d    = rx_data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    if (os_tick_s) begin
      if (state_q != IDLE) begin
        os_cnt_d = os_cnt_q + 4'd1;
      end else begin
        os_cnt_d = 4'd0;
      end

      if (os_cnt_q == CNT_S7) begin
        samp_d[0] = rxd_s;
      end else if (os_cnt_q == CNT_S8) begin
        samp_d[1] = rxd_s;
      end else begin
        samp_d = samp_q;
      end

      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d   = START;
            os_cnt_d  = 4'd0;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if ((os_cnt_q == CNT_S9) && maj_s) begin
            state_d  = IDLE;
            os_cnt_d = 4'd0;
          end else if (os_cnt_q == CNT_END) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (os_cnt_q == CNT_S9) begin
            shift_d = shift_ins_s[DATA_WIDTH:1];
          end else if (os_cnt_q == CNT_END) begin
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = (PAR_MODE == NONE) ? STOP : PAR;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            state_d = DATA;
          end
        end
        PAR: begin
          if (os_cnt_q == CNT_S9) begin
            par_err_d = maj_s ^ par_exp_s;
          end else if (os_cnt_q == CNT_END) begin
            state_d = STOP;
          end else begin
            state_d = PAR;
          end
        end
        STOP: begin
          if (os_cnt_q == CNT_S9) begin
            // Leave half a bit early so the next start edge is not missed.
            state_d  = IDLE;
            os_cnt_d = 4'd0;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d    = shift_q;
              frame_err_d  = ~maj_s;
              parity_err_d = (PAR_MODE != NONE) ? par_err_q : 1'b0;
              rx_valid_d   = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            state_d = STOP;
          end
        end
        default: begin
          state_d  = IDLE;
          os_cnt_d = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counters, sample/shift registers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      os_cnt_q     <= 4'd0;
      bit_cnt_q    <= '0;
      samp_q       <= 2'b00;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: three instances (no/even/odd parity),
// directed vector table, hand-written corner sequences and random frames.
module tb_uart_rx_os16;

  localparam int CLKF    = 1_600_000;
  localparam int BAUD    = 10_000;
  localparam int BIT_CLK = 160;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rxd        [3];
  logic       rx_ready   [3];
  logic [7:0] rx_data    [3];
  logic       rx_valid   [3];
  logic       frame_err  [3];
  logic       parity_err [3];
  logic       overrun    [3];

  int checks = 0;
  int errors = 0;

  // Received words: {instance[1:0], data[7:0], frame_err, parity_err}.
  logic [11:0] got_q[$];
  int          ov_pulses [3];
  int          ov_cycles [3];
  logic        ov_prev   [3];

  always #5 clk = ~clk;

  uart_rx_os16 #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .PARITY(0)) dut0 (
    .clk(clk), .rstn(rstn), .rxd(rxd[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0]));

  uart_rx_os16 #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .PARITY(1)) dut1 (
    .clk(clk), .rstn(rstn), .rxd(rxd[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1]));

  uart_rx_os16 #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .PARITY(2)) dut2 (
    .clk(clk), .rstn(rstn), .rxd(rxd[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
    .rx_ready(rx_ready[2]), .frame_err(frame_err[2]), .parity_err(parity_err[2]), .overrun(overrun[2]));

  // Monitor: capture accepted words and count overrun pulses / high cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid[i] && rx_ready[i]) begin
        got_q.push_back({i[1:0], rx_data[i], frame_err[i], parity_err[i]});
      end
      if (overrun[i]) ov_cycles[i] <= ov_cycles[i] + 1;
      if (overrun[i] && !ov_prev[i]) ov_pulses[i] <= ov_pulses[i] + 1;
      ov_prev[i] <= overrun[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick_to(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame; an optional inverted spike of spike_w clocks starts at
  // clock offset spike_at from the start edge.
  task automatic drive_frame(input int inst, input logic [7:0] d, input logic pbit,
                             input logic stopb, input int bitlen,
                             input int spike_at, input int spike_w);
    logic [10:0] bits;
    int nb;
    bits = 11'h7ff;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (inst != 0) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = stopb;
    nb++;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < bitlen; c++) begin
        int off;
        off = b * bitlen + c;
        @(posedge clk);
        #1;
        rxd[inst] = bits[b] ^ ((off >= spike_at) && (off < spike_at + spike_w));
      end
    end
    @(posedge clk);
    #1;
    rxd[inst] = 1'b1;
  endtask

  // Reference: data and stop pass through; parity judged by counting ones.
  function automatic logic [11:0] model(input int inst, input logic [7:0] d,
                                        input logic pbit, input logic stopb);
    int ones;
    logic pe;
    ones = $countones(d) + int'(pbit);
    case (inst)
      1:       pe = (ones % 2) != 0;
      2:       pe = (ones % 2) == 0;
      default: pe = 1'b0;
    endcase
    return {inst[1:0], d, ~stopb, pe};
  endfunction

  task automatic expect_word(input string name, input logic [11:0] exp);
    logic [11:0] w;
    check({name, "_count"}, got_q.size(), 32'd1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      check(name, {20'd0, w}, {20'd0, exp});
    end
    while (got_q.size() > 0) w = got_q.pop_front();
  endtask

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       pbit;
    logic       stopb;
    logic [7:0] ed;
    logic       efe;
    logic       epe;
  } vec_t;

  vec_t vt [8];

  initial begin
    int p0, c0;
    logic [7:0] rd;
    logic rp, rs;
    int ri, rl;

    vt[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[2] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vt[3] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
    vt[4] = '{2, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[5] = '{2, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1};
    vt[6] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[7] = '{1, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};

    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxd[i]      = 1'b1;
      rx_ready[i] = 1'b1;
    end

    // Reset state, during and just after reset.
    tick_to(5);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_in%0d", i),
            {20'd0, rx_data[i], rx_valid[i], frame_err[i], parity_err[i], overrun[i]}, 32'd0);
    rstn = 1'b1;
    tick_to(50);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_out%0d", i),
            {20'd0, rx_data[i], rx_valid[i], frame_err[i], parity_err[i], overrun[i]}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      drive_frame(vt[i].inst, vt[i].d, vt[i].pbit, vt[i].stopb, BIT_CLK, -1, 0);
      tick_to(30);
      expect_word($sformatf("vec%0d", i), {vt[i].inst[1:0], vt[i].ed, vt[i].efe, vt[i].epe});
      tick_to(2 * BIT_CLK);
    end

    // Glitch rejection: 40-clock low pulse, then a real 0x3C frame.
    rxd[0] = 1'b0;
    tick_to(40);
    rxd[0] = 1'b1;
    tick_to(3 * BIT_CLK);
    check("glitch_none", got_q.size(), 32'd0);
    check("glitch_valid", {31'd0, rx_valid[0]}, 32'd0);
    drive_frame(0, 8'h3C, 1'b0, 1'b1, BIT_CLK, -1, 0);
    tick_to(30);
    expect_word("after_glitch", {2'd0, 8'h3C, 1'b0, 1'b0});
    tick_to(2 * BIT_CLK);

    // Noise spikes around the sample points of data bit 3.
    drive_frame(0, 8'h5A, 1'b0, 1'b1, BIT_CLK, 4 * BIT_CLK + 85, 1);
    tick_to(30);
    expect_word("spike1", {2'd0, 8'h5A, 1'b0, 1'b0});
    tick_to(2 * BIT_CLK);
    for (int k = 0; k < 3; k++) begin
      drive_frame(0, 8'hF7, 1'b0, 1'b1, BIT_CLK, 4 * BIT_CLK + 72 + 10 * k, 10);
      tick_to(30);
      expect_word($sformatf("spike10_%0d", k), {2'd0, 8'hF7, 1'b0, 1'b0});
      tick_to(2 * BIT_CLK);
    end

    // Random frames with small baud mismatch against the reference model.
    for (int n = 0; n < 10; n++) begin
      ri = $urandom_range(0, 2);
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      rl = $urandom_range(158, 162);
      drive_frame(ri, rd, rp, rs, rl, -1, 0);
      tick_to(30);
      expect_word($sformatf("rand%0d", n), model(ri, rd, rp, rs));
      tick_to(2 * BIT_CLK);
    end

    // Overrun: two back-to-back frames with the consumer stalled.
    rx_ready[0] = 1'b0;
    p0 = ov_pulses[0];
    c0 = ov_cycles[0];
    drive_frame(0, 8'h11, 1'b0, 1'b1, BIT_CLK, -1, 0);
    drive_frame(0, 8'h22, 1'b0, 1'b1, BIT_CLK, -1, 0);
    tick_to(30);
    check("ovr_pulses", ov_pulses[0] - p0, 32'd1);
    check("ovr_width", ov_cycles[0] - c0, 32'd1);
    check("ovr_valid", {31'd0, rx_valid[0]}, 32'd1);
    check("ovr_data_held", {24'd0, rx_data[0]}, 32'h11);
    rx_ready[0] = 1'b1;
    tick_to(1);
    rx_ready[0] = 1'b0;
    expect_word("ovr_accept", {2'd0, 8'h11, 1'b0, 1'b0});
    tick_to(1);
    check("ovr_cleared", {31'd0, rx_valid[0]}, 32'd0);
    tick_to(2 * BIT_CLK);

    // Reset mid-frame with a word held: everything returns to zero.
    drive_frame(0, 8'h5A, 1'b0, 1'b1, BIT_CLK, -1, 0);
    tick_to(30);
    check("hold_before_rst", {31'd0, rx_valid[0]}, 32'd1);
    tick_to(2 * BIT_CLK);
    fork
      drive_frame(0, 8'h00, 1'b0, 1'b1, BIT_CLK, -1, 0);
    join_none
    tick_to(4 * BIT_CLK + 80);
    rstn = 1'b0;
    tick_to(1);
    check("midrst_outputs",
          {20'd0, rx_data[0], rx_valid[0], frame_err[0], parity_err[0], overrun[0]}, 32'd0);
    tick_to(8 * BIT_CLK);
    rstn = 1'b1;
    tick_to(2 * BIT_CLK);
    check("midrst_no_word", {31'd0, rx_valid[0]}, 32'd0);
    rx_ready[0] = 1'b1;
    drive_frame(0, 8'h81, 1'b0, 1'b1, BIT_CLK, -1, 0);
    tick_to(30);
    expect_word("after_rst", {2'd0, 8'h81, 1'b0, 1'b0});
    tick_to(BIT_CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART receiver with majority-vote bit sampling, start-bit glitch rejection, optional parity checking, and a valid/ready output holding register with overrun reporting. It is the receive-side counterpart to the existing transmitter. It decodes the serial line that a `uart_tx` on the far end drives. It is a drop-in option for links where the plain receiver's single mid-bit sample is not robust enough.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, LSB first.
- `BAUD_RATE`, 115200: line bit rate.
- `CLK_FREQ`, 100_000_000: `clk` frequency in Hz.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `clk`  in  1  sole clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  DATA_WIDTH  received word. Held stable while `rx_valid` is high.
- `rx_valid`  out  1  word available.
- `rx_ready`  in  1  consumer accepts the word on a cycle where `rx_valid && rx_ready`.
- `frame_err`  out  1  the stop bit sampled low. Qualified by `rx_valid`.
- `parity_err`  out  1  parity mismatch. Qualified by `rx_valid`. Always 0 when `PARITY`=0.
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped.

## Operation
- **Synchronizer:** `rxd` passes through a 2-FF synchronizer. Both flops reset to 1.
- **Oversample tick:** `OS_DIV = CLK_FREQ / (BAUD_RATE*16)`, truncated.
  - The tick counter runs `0..OS_DIV-1` and pulses `os_tick` when it wraps.
  - Elaboration fails if `OS_DIV` < 2.
- **Bit timing:** the per-bit counter `os_cnt` (4 bits) advances on each `os_tick` and wraps 15→0.
  - Samples are captured at `os_cnt` 7, 8 and 9.
  - The bit value is the majority (2 of 3) of those samples, evaluated at `os_cnt`=9.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START: on an `os_tick` where the synced `rxd` is 0. `os_cnt` is cleared to 0 at that tick.
  - START: at `os_cnt`=9, a majority of 1 is a glitch and returns to IDLE with no output. Otherwise it moves to DATA at `os_cnt`=15.
  - DATA: shifts in `DATA_WIDTH` bits, LSB first. After the last bit, at `os_cnt`=15, it goes to PAR if `PARITY`≠0, else to STOP.
  - PAR: at `os_cnt`=9, compare the sampled bit with the XOR of the data bits. Even mode expects the XOR; odd mode expects its inverse. Go to STOP at `os_cnt`=15.
  - STOP: at `os_cnt`=9, the frame completes and the FSM returns to IDLE immediately (half-bit early, for resync margin). `frame_err` = !majority.
- **Frame completion:**
  - If the holding register is empty (`rx_valid`=0), or is being accepted in the same cycle, load `rx_data`, `frame_err` and `parity_err`, and set `rx_valid`.
  - Otherwise drop the new frame, keep the held word, and pulse `overrun`.
- **Frames with errors:** they are still delivered. Error flags travel with their word.
- **Acceptance:** `rx_valid && rx_ready` clears `rx_valid` on the next edge. `rx_data` and the flags may keep their stale values.
- **Reset:** `rstn` low at any time, including mid-frame, forces:
  - state = IDLE;
  - all counters = 0;
  - `rx_data` = 0;
  - `rx_valid`, `frame_err`, `parity_err`, `overrun` = 0.

## Timing
- The synchronizer adds 2 `clk` of latency.
- `rx_valid` rises 1 `clk` after the `os_tick` at `os_cnt`=9 of the stop bit.
- A frame spans (1 + `DATA_WIDTH` + parity + 1) × 16 `os_tick` nominally. The receiver is ready for the next start edge 6.5 bit-sixteenths before the nominal stop end.
- A simultaneous completion and acceptance in the same cycle is not an overrun. The new word is loaded and `rx_valid` stays 1.
- A low pulse shorter than about 7/16 bit does not produce a frame.
- Tolerated baud mismatch is about ±3 % over a 10-bit frame.
- `overrun` is high for exactly one `clk`.

## Structure
- **Package `uart_pkg`:** contains
  - the `rx_state_e` enum (IDLE, START, DATA, PAR, STOP);
  - the `parity_e` enum (NONE=0, EVEN=1, ODD=2);
  - the constant `OS_RATE`=16;
  - a function computing `OS_DIV` from `CLK_FREQ` and `BAUD_RATE`.
- **Sub-module `uart_os_tick`:** the parameterized tick divider, with ports `clk`, `rstn`, `os_tick`. It is shareable with a future oversampled transmitter.
- The FSM, sampler, shift register and holding register live in `uart_rx_os16`.

## Test plan
All scenarios use `CLK_FREQ`=1_600_000 and `BAUD_RATE`=10_000, giving `OS_DIV`=10 and 160 `clk` per bit.
- **Basic receive:** drive 0xA5 with `PARITY`=0 and `rx_ready`=1 → `rx_valid` pulses once with `rx_data`=0xA5, `frame_err`=0, `parity_err`=0.
- **Glitch rejection:** a 40-clk low pulse on an idle line → no `rx_valid`. A following 0x3C frame is received correctly.
- **Parity check:** `PARITY`=1, drive 0x07 with parity bit 1 → `parity_err`=0. Repeat with parity bit 0 → `parity_err`=1, `rx_data`=0x07.
- **Framing error and noise:** drive 0x55 with the stop bit held low → `frame_err`=1. Inject a 1-clk inverted spike at `os_cnt`=8 of bit 3 → that bit still decodes correctly.
- **Overrun:** hold `rx_ready`=0 and send 0x11 then 0x22 back-to-back → `overrun` pulses once, and `rx_data` stays 0x11 until accepted.
- **Reset mid-frame:** assert `rstn` low during bit 4 → all outputs 0 and state IDLE. After release, 0x81 is received correctly.
